can_fd_brs_ctrl: RTL

- Bit-rate-switch sequencer for the CAN FD receive path.
- Tracks frame phase from bit-stream-processor strobes and drives the bit-timing parameter set (prescaler, segments, SJW, triple sampling) into the bit timing logic.
- Selects the nominal set in arbitration/control/ACK/EOF phases and the data set between the BRS and CRC-delimiter sample points.
- Configuration is captured in shadow registers while the core is in reset mode.

---
 rtl/can_fd_brs_ctrl_if.sv | 58 +++++
 rtl/can_fd_brs_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/can_fd_brs_ctrl_if.sv
// CAN FD bit-rate-switch bundle: shadow config, BSP strobes
// and the active bit-timing set handed to the BTL.
interface can_fd_brs_ctrl_if;
  logic       reset_mode;
  logic       en_fd;
  logic [5:0] nom_brp;
  logic [3:0] nom_tseg1;
  logic [2:0] nom_tseg2;
  logic [1:0] nom_sjw;
  logic       nom_sam;
  logic [5:0] dat_brp;
  logic [3:0] dat_tseg1;
  logic [2:0] dat_tseg2;
  logic [1:0] dat_sjw;
  logic       sample_point;
  logic       sampled_bit;
  logic       fdf_bit;
  logic       brs_bit;
  logic       crc_delim_bit;
  logic       go_error_frame;
  logic       rx_idle;
  logic [5:0] btl_brp;
  logic [3:0] btl_tseg1;
  logic [2:0] btl_tseg2;
  logic [1:0] btl_sjw;
  logic       btl_sam;
  logic       data_phase;
  logic       btl_reload;
  logic       brs_timeout;

  modport master (
    output reset_mode, en_fd,
    output nom_brp, nom_tseg1, nom_tseg2,
    output nom_sjw, nom_sam,
    output dat_brp, dat_tseg1, dat_tseg2,
    output dat_sjw,
    output sample_point, sampled_bit,
    output fdf_bit, brs_bit, crc_delim_bit,
    output go_error_frame, rx_idle,
    input  btl_brp, btl_tseg1, btl_tseg2,
    input  btl_sjw, btl_sam,
    input  data_phase, btl_reload, brs_timeout
  );

  modport slave (
    input  reset_mode, en_fd,
    input  nom_brp, nom_tseg1, nom_tseg2,
    input  nom_sjw, nom_sam,
    input  dat_brp, dat_tseg1, dat_tseg2,
    input  dat_sjw,
    input  sample_point, sampled_bit,
    input  fdf_bit, brs_bit, crc_delim_bit,
    input  go_error_frame, rx_idle,
    output btl_brp, btl_tseg1, btl_tseg2,
    output btl_sjw, btl_sam,
    output data_phase, btl_reload, brs_timeout
  );
endinterface

// File: rtl/can_fd_brs_ctrl.sv
// CAN FD bit-rate-switch sequencer: picks the nominal or
// data bit-timing set from frame phase, with a watchdog.
module can_fd_brs_ctrl #(
  parameter int MAX_DATA_BITS = 600,
  parameter int CNT_W         = 10
) (
  input logic              clk,
  input logic              rst,
  can_fd_brs_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_NOM,
    S_ARMED,
    S_DATA
  } state_t;

  localparam logic [CNT_W-1:0] LP_WD_LAST =
    CNT_W'(MAX_DATA_BITS - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_wd_fire;
  logic             w_reload;
  logic             w_enter;
  logic             w_leave;

  logic [5:0]       r_nom_brp;
  logic [3:0]       r_nom_tseg1;
  logic [2:0]       r_nom_tseg2;
  logic [1:0]       r_nom_sjw;
  logic             r_nom_sam;
  logic [5:0]       r_dat_brp;
  logic [3:0]       r_dat_tseg1;
  logic [2:0]       r_dat_tseg2;
  logic [1:0]       r_dat_sjw;

  logic [5:0]       r_btl_brp;
  logic [3:0]       r_btl_tseg1;
  logic [2:0]       r_btl_tseg2;
  logic [1:0]       r_btl_sjw;
  logic             r_btl_sam;
  logic             r_data_phase;
  logic             r_reload;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cnt;

  // Shadow config follows the inputs only in reset mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nom_brp   <= '0;
      r_nom_tseg1 <= '0;
      r_nom_tseg2 <= '0;
      r_nom_sjw   <= '0;
      r_nom_sam   <= 1'b0;
      r_dat_brp   <= '0;
      r_dat_tseg1 <= '0;
      r_dat_tseg2 <= '0;
      r_dat_sjw   <= '0;
    end else if (bus.reset_mode) begin
      r_nom_brp   <= bus.nom_brp;
      r_nom_tseg1 <= bus.nom_tseg1;
      r_nom_tseg2 <= bus.nom_tseg2;
      r_nom_sjw   <= bus.nom_sjw;
      r_nom_sam   <= bus.nom_sam;
      r_dat_brp   <= bus.dat_brp;
      r_dat_tseg1 <= bus.dat_tseg1;
      r_dat_tseg2 <= bus.dat_tseg2;
      r_dat_sjw   <= bus.dat_sjw;
    end
  end

  // Frame-phase state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_NOM;
    else     r_state <= w_next;
  end

  // Next phase; error/idle override every sample-point event.
  always_comb begin
    w_next    = r_state;
    w_wd_fire = 1'b0;
    if (bus.reset_mode) begin
      w_next = S_NOM;
    end else if (bus.go_error_frame || bus.rx_idle) begin
      w_next = S_NOM;
    end else if (bus.sample_point) begin
      unique case (r_state)
        S_NOM: begin
          if (bus.fdf_bit && bus.sampled_bit && bus.en_fd)
            w_next = S_ARMED;
        end
        S_ARMED: begin
          if (bus.brs_bit)
            w_next = bus.sampled_bit ? S_DATA : S_NOM;
        end
        S_DATA: begin
          if (bus.crc_delim_bit) begin
            w_next = S_NOM;
          end else if (r_cnt == LP_WD_LAST) begin
            w_next    = S_NOM;
            w_wd_fire = 1'b1;
          end
        end
        default: w_next = S_NOM;
      endcase
    end
  end

  assign w_enter  = (r_state != S_DATA) && (w_next == S_DATA);
  assign w_leave  = (r_state == S_DATA) && (w_next != S_DATA);
  assign w_reload = w_enter || w_leave;

  // Active timing set lands one cycle after the deciding strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btl_brp    <= '0;
      r_btl_tseg1  <= '0;
      r_btl_tseg2  <= '0;
      r_btl_sjw    <= '0;
      r_btl_sam    <= 1'b0;
      r_data_phase <= 1'b0;
      r_reload     <= 1'b0;
    end else if (w_next == S_DATA) begin
      r_btl_brp    <= r_dat_brp;
      r_btl_tseg1  <= r_dat_tseg1;
      r_btl_tseg2  <= r_dat_tseg2;
      r_btl_sjw    <= r_dat_sjw;
      r_btl_sam    <= 1'b0;
      r_data_phase <= 1'b1;
      r_reload     <= w_reload;
    end else begin
      r_btl_brp    <= r_nom_brp;
      r_btl_tseg1  <= r_nom_tseg1;
      r_btl_tseg2  <= r_nom_tseg2;
      r_btl_sjw    <= r_nom_sjw;
      r_btl_sam    <= r_nom_sam;
      r_data_phase <= 1'b0;
      r_reload     <= w_reload;
    end
  end

  // Data-phase sample counter feeding the watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (w_enter || w_leave)
      r_cnt <= '0;
    else if (r_state == S_DATA && bus.sample_point
             && r_cnt != {CNT_W{1'b1}})
      r_cnt <= r_cnt + 1'b1;
  end

  // Sticky watchdog flag, cleared by reset mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_timeout <= 1'b0;
    else if (bus.reset_mode) r_timeout <= 1'b0;
    else if (w_wd_fire)      r_timeout <= 1'b1;
  end

  assign bus.btl_brp     = r_btl_brp;
  assign bus.btl_tseg1   = r_btl_tseg1;
  assign bus.btl_tseg2   = r_btl_tseg2;
  assign bus.btl_sjw     = r_btl_sjw;
  assign bus.btl_sam     = r_btl_sam;
  assign bus.data_phase  = r_data_phase;
  assign bus.btl_reload  = r_reload;
  assign bus.brs_timeout = r_timeout;

endmodule
